stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
- Multi-cycle stack sequencer for the pipelined core's memory stage.
- Owns the stack-pointer register and converts PUSH/POP/CALL/RET/INT/RTI requests into one-word-per-cycle accesses on the 16-bit data-memory port.
- Returns popped data and restored flags to the pipeline; holds the pipeline off while busy.

Parameters:
- SP_RESET, 32'h000F_FFFF, stack-pointer value after reset (top of the 2^20-word data memory).
- DW, 16, memory word width.
- FW, 4, flag-register width.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-high reset
- i_valid  in  1  request strobe
- i_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 INT, 6 RTI, 7 reserved
- i_push_data  in  32  register value (PUSH uses [15:0]) or return PC (CALL/INT)
- i_flags  in  FW  flags saved by INT
- o_ready  out  1  request accepted this cycle if i_valid=1
- o_done  out  1  one-cycle completion pulse
- o_pop_data  out  32  POP result (zero-extended) or restored PC (RET/RTI)
- o_flags  out  FW  flags restored by RTI
- o_sp  out  32  current stack pointer
- o_mem_addr  out  32  memory address
- o_mem_wdata  out  DW  memory write data
- o_mem_we  out  1  memory write enable
- o_mem_re  out  1  memory read enable
- i_mem_rdata  in  DW  read data, valid the cycle after o_mem_re

Behaviour:
- Reset (async, i_reset=1): state IDLE; o_sp=SP_RESET; o_pop_data=0, o_flags=0, o_done=0, o_mem_we=0, o_mem_re=0, o_mem_addr=0, o_mem_wdata=0.
- Reset mid-operation aborts immediately; no further memory accesses are issued.
- States: IDLE, WRITE, READ, RWAIT, DONE.
- Handshake: o_ready=1 in IDLE and DONE only. A request is accepted on i_valid & o_ready.
  - NOP and op 7: ignored; stay or return to IDLE; no o_done.
  - i_valid while busy: ignored; no queueing.
- Writes (post-decrement), one word per cycle in WRITE: o_mem_we=1, o_mem_addr=SP, SP<=SP-1.
  - PUSH: i_push_data[15:0]; 1 word.
  - CALL: PC[31:16], then PC[15:0]; 2 words.
  - INT: PC[31:16], PC[15:0], then {12'b0, flags}; 3 words.
- Reads (pre-increment), one word per cycle in READ: o_mem_re=1, o_mem_addr=SP+1, SP<=SP+1. Data is captured the following cycle; RWAIT captures the final word.
  - POP: 1 word to o_pop_data[15:0]; [31:16]=0.
  - RET: PC[15:0] first, then PC[31:16].
  - RTI: flags word first (o_flags <= rdata[FW-1:0]), then PC[15:0], then PC[31:16].
- Latency (accept at cycle t):
  - PUSH: o_done at t+2.
  - CALL: o_done at t+3.
  - INT: o_done at t+4.
  - POP: o_done at t+3.
  - RET: o_done at t+4.
  - RTI: o_done at t+5.
  - o_pop_data and o_flags are stable from the DONE cycle until the next read operation completes.
- DONE lasts one cycle. A new request may be accepted in DONE (back-to-back); otherwise return to IDLE.
- o_sp always reflects the registered SP.
- SP arithmetic is modulo 2^32: wrap at 0 and 0xFFFF_FFFF; no overflow or underflow error.
- o_mem_we and o_mem_re are never both high. Both are 0 in IDLE, RWAIT and DONE.

Decomposition:
- Shared package `stack_pkg`:
  - op enum (NOP..RTI)
  - state enum
  - SP_RESET default
  - per-op word-count constants
- No sub-module required. SP ±1 step and the word counter live in this block.

Test Plan:
- Reset, then PUSH i_push_data=32'h0000_ABCD -> at t+1: we=1, addr=0x000F_FFFF, wdata=0xABCD; then o_sp=0x000F_FFFE; o_done at t+2.
- CALL with PC=0x0001_2345, then RET with memory model returning stored words -> writes 0x0001@0xFFFFF and 0x2345@0xFFFFE; RET reads 0xFFFFE then 0xFFFFF; o_pop_data=0x0001_2345; o_sp back to 0x000F_FFFF.
- INT with PC=0x0000_0100, flags=4'b1010, then RTI -> INT writes three words, o_sp=0x000F_FFFC; RTI gives o_flags=4'b1010, o_pop_data=0x0000_0100, o_sp=0x000F_FFFF, o_done at t+5.
- SP wrap: force SP to 0 via reset value SP_RESET=0, PUSH -> write at addr 0, o_sp=0xFFFF_FFFF; then POP -> read at 0, o_sp=0.
- Busy and back-to-back: i_valid held during CALL -> only one CALL performed; PUSH presented in DONE cycle -> accepted, write next cycle.
- Async reset asserted mid-RTI (after first read) -> outputs zero immediately, o_sp=SP_RESET, no o_done, no further we/re.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and constants for the stack sequencer: opcodes, FSM states,
// reset stack pointer and the number of memory words each opcode moves.
package stack_pkg;

  localparam logic [31:0] SP_RESET_DEF = 32'h000F_FFFF;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_INT  = 3'd5,
    OP_RTI  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RWAIT,
    S_DONE
  } state_e;

  localparam logic [1:0] NW_PUSH = 2'd1;
  localparam logic [1:0] NW_CALL = 2'd2;
  localparam logic [1:0] NW_INT  = 2'd3;
  localparam logic [1:0] NW_POP  = 2'd1;
  localparam logic [1:0] NW_RET  = 2'd2;
  localparam logic [1:0] NW_RTI  = 2'd3;

  // Zero words marks an opcode that is accepted but does nothing.
  function automatic logic [1:0] op_words(op_e op);
    case (op)
      OP_PUSH: op_words = NW_PUSH;
      OP_CALL: op_words = NW_CALL;
      OP_INT:  op_words = NW_INT;
      OP_POP:  op_words = NW_POP;
      OP_RET:  op_words = NW_RET;
      OP_RTI:  op_words = NW_RTI;
      default: op_words = 2'd0;
    endcase
  endfunction

  function automatic logic op_is_write(op_e op);
    op_is_write = (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
  endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// Pipeline request/response and data-memory port of the stack sequencer.
interface stack_ctrl_if #(
  parameter int DW = 16,
  parameter int FW = 4
);
  logic          i_valid;
  logic [2:0]    i_op;
  logic [31:0]   i_push_data;
  logic [FW-1:0] i_flags;
  logic          o_ready;
  logic          o_done;
  logic [31:0]   o_pop_data;
  logic [FW-1:0] o_flags;
  logic [31:0]   o_sp;
  logic [31:0]   o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          o_mem_we;
  logic          o_mem_re;
  logic [DW-1:0] i_mem_rdata;

  modport slave (
    input  i_valid, i_op, i_push_data, i_flags, i_mem_rdata,
    output o_ready, o_done, o_pop_data, o_flags, o_sp,
           o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re
  );

  modport master (
    output i_valid, i_op, i_push_data, i_flags, i_mem_rdata,
    input  o_ready, o_done, o_pop_data, o_flags, o_sp,
           o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re
  );
endinterface

// File: rtl/stack_ctrl.sv
// Stack sequencer: turns PUSH/POP/CALL/RET/INT/RTI into one-word-per-cycle
// accesses on the data-memory port and owns the stack pointer.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter logic [31:0] SP_RESET = SP_RESET_DEF,
  parameter int          DW       = 16,
  parameter int          FW       = 4
) (
  input  logic     i_clk,
  input  logic     i_reset,
  stack_ctrl_if.slave bus
);

  state_e        state, state_nxt;
  op_e           op_q, op_in;
  logic [31:0]   sp, pc_q, pop_q;
  logic [FW-1:0] flg_q, flags_q;
  logic [1:0]    cnt, cap_idx, cap_j;
  logic          rdy, real_req, last, cap_en;
  logic [DW-1:0] wr_word;

  assign op_in    = op_e'(bus.i_op);
  assign rdy      = (state == S_IDLE) || (state == S_DONE);
  assign real_req = bus.i_valid && rdy && (op_words(op_in) != 2'd0);
  assign last     = (cnt == op_words(op_q) - 2'd1);

  // Read data lags the address by a cycle, so each capture belongs to the
  // word issued one step earlier; RTI's leading flags word shifts PC words up.
  assign cap_en  = ((state == S_READ) && (cnt != 2'd0)) || (state == S_RWAIT);
  assign cap_idx = cnt - 2'd1;
  assign cap_j   = (op_q == OP_RTI) ? cap_idx - 2'd1 : cap_idx;

  always_comb begin
    wr_word = '0;
    if (op_q == OP_PUSH) wr_word = DW'(pc_q[15:0]);
    else begin
      case (cnt)
        2'd0:    wr_word = DW'(pc_q[31:16]);
        2'd1:    wr_word = DW'(pc_q[15:0]);
        default: wr_word = DW'(flg_q);
      endcase
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_re    = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (real_req) state_nxt = op_is_write(op_in) ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        bus.o_mem_we    = 1'b1;
        bus.o_mem_addr  = sp;
        bus.o_mem_wdata = wr_word;
        if (last) state_nxt = S_DONE;
      end
      S_READ: begin
        bus.o_mem_re   = 1'b1;
        bus.o_mem_addr = sp + 32'd1;
        if (last) state_nxt = S_RWAIT;
      end
      S_RWAIT: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= S_IDLE;
      sp      <= SP_RESET;
      cnt     <= 2'd0;
      op_q    <= OP_NOP;
      pc_q    <= '0;
      flg_q   <= '0;
      pop_q   <= '0;
      flags_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          cnt <= 2'd0;
          if (real_req) begin
            op_q  <= op_in;
            pc_q  <= bus.i_push_data;
            flg_q <= bus.i_flags;
          end
        end
        S_WRITE: begin
          sp  <= sp - 32'd1;
          cnt <= cnt + 2'd1;
        end
        S_READ: begin
          sp  <= sp + 32'd1;
          cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
      if (cap_en) begin
        if ((op_q == OP_RTI) && (cap_idx == 2'd0)) flags_q <= bus.i_mem_rdata[FW-1:0];
        else if (cap_j == 2'd0) begin
          if (op_q == OP_POP) pop_q <= {16'h0000, bus.i_mem_rdata[15:0]};
          else                pop_q[15:0] <= bus.i_mem_rdata[15:0];
        end else              pop_q[31:16] <= bus.i_mem_rdata[15:0];
      end
    end
  end

  assign bus.o_ready    = rdy;
  assign bus.o_done     = (state == S_DONE);
  assign bus.o_sp       = sp;
  assign bus.o_pop_data = pop_q;
  assign bus.o_flags    = flags_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl: one instance at the default reset SP, one at
// SP_RESET=0 for the wrap case, each with a small word-addressed memory model.
module tb_stack_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  stack_ctrl_if #(.DW(16), .FW(4)) ifa ();
  stack_ctrl_if #(.DW(16), .FW(4)) ifb ();

  stack_ctrl u_a (.i_clk(clk), .i_reset(rst), .bus(ifa));
  stack_ctrl #(.SP_RESET(32'h0000_0000)) u_b (.i_clk(clk), .i_reset(rst), .bus(ifb));

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];

  always @(posedge clk) begin
    if (ifa.o_mem_we) mem_a[ifa.o_mem_addr[7:0]] <= ifa.o_mem_wdata;
    if (ifa.o_mem_re) ifa.i_mem_rdata <= mem_a[ifa.o_mem_addr[7:0]];
    if (ifb.o_mem_we) mem_b[ifb.o_mem_addr[7:0]] <= ifb.o_mem_wdata;
    if (ifb.o_mem_re) ifb.i_mem_rdata <= mem_b[ifb.o_mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic req_a(input logic [2:0] op, input logic [31:0] d, input logic [3:0] f);
    ifa.i_valid = 1'b1; ifa.i_op = op; ifa.i_push_data = d; ifa.i_flags = f;
  endtask

  task automatic idle_a();
    ifa.i_valid = 1'b0; ifa.i_op = 3'd0; ifa.i_push_data = '0; ifa.i_flags = '0;
  endtask

  task automatic req_b(input logic [2:0] op, input logic [31:0] d);
    ifb.i_valid = 1'b1; ifb.i_op = op; ifb.i_push_data = d; ifb.i_flags = '0;
  endtask

  task automatic idle_b();
    ifb.i_valid = 1'b0; ifb.i_op = 3'd0; ifb.i_push_data = '0; ifb.i_flags = '0;
  endtask

  // Memory-port snapshot of instance A: we, re, address, write data.
  task automatic mem_a_chk(input string tag, input logic we, input logic re,
                           input logic [31:0] addr, input logic [15:0] wd);
    chk({tag, ".we"},    32'(ifa.o_mem_we),    32'(we));
    chk({tag, ".re"},    32'(ifa.o_mem_re),    32'(re));
    chk({tag, ".addr"},  ifa.o_mem_addr,       addr);
    chk({tag, ".wdata"}, 32'(ifa.o_mem_wdata), 32'(wd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_a(); idle_b();
    ifa.i_mem_rdata = '0; ifb.i_mem_rdata = '0;
    tick(); tick();
    // reset state
    chk("rst.sp",    ifa.o_sp, 32'h000F_FFFF);
    chk("rst.pop",   ifa.o_pop_data, 32'h0);
    chk("rst.flags", 32'(ifa.o_flags), 32'h0);
    chk("rst.done",  32'(ifa.o_done), 32'h0);
    chk("rst.ready", 32'(ifa.o_ready), 32'h1);
    mem_a_chk("rst", 1'b0, 1'b0, 32'h0, 16'h0);
    chk("rst.sp_b",  ifb.o_sp, 32'h0);
    rst = 1'b0;
    tick();

    // PUSH
    req_a(3'd1, 32'h0000_ABCD, 4'h0); tick(); idle_a();
    mem_a_chk("push.t1", 1'b1, 1'b0, 32'h000F_FFFF, 16'hABCD);
    chk("push.t1.done", 32'(ifa.o_done), 32'h0);
    tick();
    chk("push.t2.done", 32'(ifa.o_done), 32'h1);
    chk("push.t2.sp",   ifa.o_sp, 32'h000F_FFFE);
    chk("push.t2.we",   32'(ifa.o_mem_we), 32'h0);
    tick();
    chk("push.t3.done", 32'(ifa.o_done), 32'h0);

    // POP
    req_a(3'd2, 32'h0, 4'h0); tick(); idle_a();
    mem_a_chk("pop.t1", 1'b0, 1'b1, 32'h000F_FFFF, 16'h0);
    tick();
    mem_a_chk("pop.t2", 1'b0, 1'b0, 32'h0, 16'h0);
    chk("pop.t2.done", 32'(ifa.o_done), 32'h0);
    tick();
    chk("pop.t3.done", 32'(ifa.o_done), 32'h1);
    chk("pop.t3.data", ifa.o_pop_data, 32'h0000_ABCD);
    chk("pop.t3.sp",   ifa.o_sp, 32'h000F_FFFF);
    tick();

    // CALL with valid held while busy
    req_a(3'd3, 32'h0001_2345, 4'h0); tick();
    mem_a_chk("call.t1", 1'b1, 1'b0, 32'h000F_FFFF, 16'h0001);
    chk("call.t1.ready", 32'(ifa.o_ready), 32'h0);
    tick();
    mem_a_chk("call.t2", 1'b1, 1'b0, 32'h000F_FFFE, 16'h2345);
    idle_a(); tick();
    chk("call.t3.done", 32'(ifa.o_done), 32'h1);
    chk("call.t3.sp",   ifa.o_sp, 32'h000F_FFFD);
    tick();
    chk("call.t4.done", 32'(ifa.o_done), 32'h0);
    chk("call.t4.we",   32'(ifa.o_mem_we), 32'h0);
    chk("call.t4.sp",   ifa.o_sp, 32'h000F_FFFD);

    // RET
    req_a(3'd4, 32'h0, 4'h0); tick(); idle_a();
    mem_a_chk("ret.t1", 1'b0, 1'b1, 32'h000F_FFFE, 16'h0);
    tick();
    mem_a_chk("ret.t2", 1'b0, 1'b1, 32'h000F_FFFF, 16'h0);
    tick();
    chk("ret.t3.re",   32'(ifa.o_mem_re), 32'h0);
    chk("ret.t3.done", 32'(ifa.o_done), 32'h0);
    tick();
    chk("ret.t4.done", 32'(ifa.o_done), 32'h1);
    chk("ret.t4.pc",   ifa.o_pop_data, 32'h0001_2345);
    chk("ret.t4.sp",   ifa.o_sp, 32'h000F_FFFF);
    tick();

    // INT
    req_a(3'd5, 32'h0000_0100, 4'b1010); tick(); idle_a();
    mem_a_chk("int.t1", 1'b1, 1'b0, 32'h000F_FFFF, 16'h0000);
    tick();
    mem_a_chk("int.t2", 1'b1, 1'b0, 32'h000F_FFFE, 16'h0100);
    tick();
    mem_a_chk("int.t3", 1'b1, 1'b0, 32'h000F_FFFD, 16'h000A);
    tick();
    chk("int.t4.done", 32'(ifa.o_done), 32'h1);
    chk("int.t4.sp",   ifa.o_sp, 32'h000F_FFFC);
    tick();

    // RTI
    req_a(3'd6, 32'h0, 4'h0); tick(); idle_a();
    mem_a_chk("rti.t1", 1'b0, 1'b1, 32'h000F_FFFD, 16'h0);
    tick();
    mem_a_chk("rti.t2", 1'b0, 1'b1, 32'h000F_FFFE, 16'h0);
    tick();
    mem_a_chk("rti.t3", 1'b0, 1'b1, 32'h000F_FFFF, 16'h0);
    tick();
    chk("rti.t4.re",    32'(ifa.o_mem_re), 32'h0);
    chk("rti.t4.done",  32'(ifa.o_done), 32'h0);
    tick();
    chk("rti.t5.done",  32'(ifa.o_done), 32'h1);
    chk("rti.t5.flags", 32'(ifa.o_flags), 32'hA);
    chk("rti.t5.pc",    ifa.o_pop_data, 32'h0000_0100);
    chk("rti.t5.sp",    ifa.o_sp, 32'h000F_FFFF);
    tick();

    // NOP and reserved opcode are ignored
    req_a(3'd0, 32'h1234, 4'h0); tick(); idle_a();
    chk("nop.done", 32'(ifa.o_done), 32'h0);
    mem_a_chk("nop", 1'b0, 1'b0, 32'h0, 16'h0);
    req_a(3'd7, 32'h1234, 4'h0); tick(); idle_a();
    chk("op7.done", 32'(ifa.o_done), 32'h0);
    mem_a_chk("op7", 1'b0, 1'b0, 32'h0, 16'h0);
    chk("op7.sp",   ifa.o_sp, 32'h000F_FFFF);
    chk("op7.pop",  ifa.o_pop_data, 32'h0000_0100);

    // back-to-back PUSH accepted in DONE
    req_a(3'd1, 32'h0000_1111, 4'h0); tick(); idle_a();
    mem_a_chk("b2b.t1", 1'b1, 1'b0, 32'h000F_FFFF, 16'h1111);
    tick();
    chk("b2b.t2.done",  32'(ifa.o_done), 32'h1);
    chk("b2b.t2.ready", 32'(ifa.o_ready), 32'h1);
    req_a(3'd1, 32'h0000_2222, 4'h0); tick(); idle_a();
    mem_a_chk("b2b.t3", 1'b1, 1'b0, 32'h000F_FFFE, 16'h2222);
    chk("b2b.t3.done", 32'(ifa.o_done), 32'h0);
    tick();
    chk("b2b.t4.done", 32'(ifa.o_done), 32'h1);
    chk("b2b.t4.sp",   ifa.o_sp, 32'h000F_FFFD);
    tick();

    // async reset in the middle of RTI
    req_a(3'd6, 32'h0, 4'h0); tick(); idle_a();
    mem_a_chk("abort.t1", 1'b0, 1'b1, 32'h000F_FFFE, 16'h0);
    tick();
    mem_a_chk("abort.t2", 1'b0, 1'b1, 32'h000F_FFFF, 16'h0);
    chk("abort.t2.flags", 32'(ifa.o_flags), 32'hA);
    rst = 1'b1;
    #1;
    mem_a_chk("abort.rst", 1'b0, 1'b0, 32'h0, 16'h0);
    chk("abort.rst.sp",    ifa.o_sp, 32'h000F_FFFF);
    chk("abort.rst.pop",   ifa.o_pop_data, 32'h0);
    chk("abort.rst.flags", 32'(ifa.o_flags), 32'h0);
    chk("abort.rst.done",  32'(ifa.o_done), 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    mem_a_chk("abort.post", 1'b0, 1'b0, 32'h0, 16'h0);
    chk("abort.post.done",  32'(ifa.o_done), 32'h0);
    chk("abort.post.ready", 32'(ifa.o_ready), 32'h1);
    chk("abort.post.sp",    ifa.o_sp, 32'h000F_FFFF);

    // SP wrap on the SP_RESET=0 instance
    req_b(3'd1, 32'h0000_5A5A); tick(); idle_b();
    chk("wrap.push.we",    32'(ifb.o_mem_we), 32'h1);
    chk("wrap.push.addr",  ifb.o_mem_addr, 32'h0);
    chk("wrap.push.wdata", 32'(ifb.o_mem_wdata), 32'h5A5A);
    tick();
    chk("wrap.push.done",  32'(ifb.o_done), 32'h1);
    chk("wrap.push.sp",    ifb.o_sp, 32'hFFFF_FFFF);
    tick();
    req_b(3'd2, 32'h0); tick(); idle_b();
    chk("wrap.pop.re",   32'(ifb.o_mem_re), 32'h1);
    chk("wrap.pop.addr", ifb.o_mem_addr, 32'h0);
    tick(); tick();
    chk("wrap.pop.done", 32'(ifb.o_done), 32'h1);
    chk("wrap.pop.data", ifb.o_pop_data, 32'h0000_5A5A);
    chk("wrap.pop.sp",   ifb.o_sp, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
